// File: rtl/sram_access_pkg.sv
// Shared types and helpers for the SRAM access controller.
// Width codes follow the CPU memory-stage encoding; 2'b11 behaves as a word.
package sram_access_pkg;

   localparam int NB = 4;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      RD_SPLIT,
      RD_LAST,
      WR_SPLIT
   } state_t;

   // An access needs two RAM beats when it runs past byte lane 3.
   function automatic logic is_split(input logic [1:0] off, input logic [1:0] width);
      case (width)
         W_BYTE:  return 1'b0;
         W_HALF:  return off == 2'd3;
         W_WORD:  return off != 2'd0;
         default: return off != 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sram_lane_shifter.sv
// Byte-lane alignment for one direction: store data is shifted left into lanes,
// load data is shifted right out of a two-word window and sign/zero extended.
module sram_lane_shifter
   import sram_access_pkg::*;
#(
   parameter bit LOAD = 1'b0
) (
   input  logic [1:0]        off,
   input  logic [1:0]        width,
   input  logic              sign_ext,
   input  logic [2*NB*8-1:0] din,
   output logic [2*NB*8-1:0] dout,
   output logic [2*NB-1:0]   lanes
);

   logic [2*NB-1:0] mask;
   logic [31:0]     shr;
   logic [31:0]     ext;

   always_comb begin
      mask = 8'h0F;
      case (width)
         W_BYTE:  mask = 8'h01;
         W_HALF:  mask = 8'h03;
         default: mask = 8'h0F;
      endcase
      lanes = mask << off;

      shr = 32'(din >> {off, 3'b000});
      ext = shr;
      case (width)
         W_BYTE:  ext = {{24{sign_ext & shr[7]}}, shr[7:0]};
         W_HALF:  ext = {{16{sign_ext & shr[15]}}, shr[15:0]};
         default: ext = shr;
      endcase

      dout = LOAD ? {32'b0, ext} : (din << {off, 3'b000});
   end

endmodule

// File: rtl/sram_access_ctrl.sv
// Turns byte-addressed CPU loads/stores into word beats on a single-port RAM,
// splitting accesses that cross a word boundary into two consecutive beats.
module sram_access_ctrl
   import sram_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int EXT_WIDTH  = 1
) (
   input  logic                            clk,
   input  logic                            sync_reset,
   input  logic                            mem_req,
   input  logic                            mem_we,
   input  logic [ADDR_WIDTH+1:0]           mem_addr,
   input  logic [1:0]                      mem_width,
   input  logic                            mem_sign_ext,
   input  logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [EXT_WIDTH-1:0]            mem_wext,
   output logic                            mem_ready,
   output logic                            mem_done,
   output logic [DATA_WIDTH-1:0]           mem_rdata,
   output logic [EXT_WIDTH-1:0]            mem_rext,
   output logic [ADDR_WIDTH-1:0]           ram_addr,
   output logic [EXT_WIDTH+DATA_WIDTH-1:0] ram_din,
   output logic [NB-1:0]                   ram_write_en,
   input  logic [EXT_WIDTH+DATA_WIDTH-1:0] ram_dout
);

   state_t                state, state_nxt;
   logic                  accept, req_split;
   logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
   logic [1:0]            off_q, width_q;
   logic                  sign_q, split_q;
   logic [EXT_WIDTH-1:0]  wext_q;
   logic [31:0]           hi_q, buf_q;
   logic [NB-1:0]         hi_lanes_q;
   logic [63:0]           st_dout, ld_din, ld_dout;
   logic [2*NB-1:0]       st_lanes, ld_lanes;
   logic                  unused_ld;

   assign mem_ready = (state == IDLE) & ~sync_reset;
   assign accept    = mem_req & mem_ready;
   assign req_split = is_split(mem_addr[1:0], mem_width);
   assign addr_inc  = addr_q + ADDR_WIDTH'(1);
   assign ld_din    = {ram_dout[31:0], split_q ? buf_q : ram_dout[31:0]};
   assign unused_ld = &{1'b0, ld_dout[63:32], ld_lanes};

   sram_lane_shifter #(.LOAD(1'b0)) u_st_shift (
      .off      (mem_addr[1:0]),
      .width    (mem_width),
      .sign_ext (1'b0),
      .din      ({32'b0, mem_wdata}),
      .dout     (st_dout),
      .lanes    (st_lanes)
   );

   sram_lane_shifter #(.LOAD(1'b1)) u_ld_shift (
      .off      (off_q),
      .width    (width_q),
      .sign_ext (sign_q),
      .din      (ld_din),
      .dout     (ld_dout),
      .lanes    (ld_lanes)
   );

   always_comb begin
      state_nxt    = state;
      ram_addr     = '0;
      ram_din      = '0;
      ram_write_en = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               ram_addr = mem_addr[ADDR_WIDTH+1:2];
               if (mem_we) begin
                  ram_din      = {mem_wext, st_dout[31:0]};
                  ram_write_en = st_lanes[NB-1:0];
                  state_nxt    = req_split ? WR_SPLIT : IDLE;
               end else begin
                  state_nxt = req_split ? RD_SPLIT : RD_LAST;
               end
            end
         end
         RD_SPLIT: begin
            ram_addr  = addr_inc;
            state_nxt = RD_LAST;
         end
         RD_LAST: begin
            ram_addr  = split_q ? addr_inc : addr_q;
            state_nxt = IDLE;
         end
         WR_SPLIT: begin
            ram_addr = addr_inc;
            ram_din  = {wext_q, hi_q};
            // Beat 1 is already in the RAM; a reset here only drops beat 2.
            if (!sync_reset) ram_write_en = hi_lanes_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state     <= IDLE;
         mem_done  <= 1'b0;
         mem_rdata <= '0;
         mem_rext  <= '0;
      end else begin
         state    <= state_nxt;
         mem_done <= 1'b0;
         case (state)
            IDLE:     if (accept && mem_we && !req_split) mem_done <= 1'b1;
            WR_SPLIT: mem_done <= 1'b1;
            RD_LAST: begin
               mem_done  <= 1'b1;
               mem_rdata <= ld_dout[31:0];
               mem_rext  <= ram_dout[DATA_WIDTH +: EXT_WIDTH];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q     <= mem_addr[ADDR_WIDTH+1:2];
         off_q      <= mem_addr[1:0];
         width_q    <= mem_width;
         sign_q     <= mem_sign_ext;
         split_q    <= req_split;
         wext_q     <= mem_wext;
         hi_q       <= st_dout[63:32];
         hi_lanes_q <= st_lanes[2*NB-1:NB];
      end
      if (state == RD_SPLIT) buf_q <= ram_dout[31:0];
   end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Initiator-side controller that turns byte-addressed load/store requests from the CPU memory stage into word-wide accesses on `single_port_ram`'s port (`addr`, `din`, `write_en`, `dout`; 1-cycle registered read latency). It handles byte, half-word and word accesses, including unaligned ones that cross a word boundary, which it splits into two RAM beats. It also sign- or zero-extends read data, and drives and returns the RAM's extension bits.

## Interface
- `ADDR_WIDTH`, 14: RAM word-address width.
- `DATA_WIDTH`, 32: RAM data width. Only 32 is supported; there are NB = 4 byte lanes.
- `EXT_WIDTH`, 1: extension bits stored alongside each RAM word.

Ports:
- `clk`  in  1: sole clock.
- `sync_reset`  in  1: synchronous, active-high reset.
- `mem_req`  in  1: request valid.
- `mem_we`  in  1: 1 = store, 0 = load.
- `mem_addr`  in  ADDR_WIDTH+2: byte address.
- `mem_width`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `mem_sign_ext`  in  1: sign-extend load data.
- `mem_wdata`  in  32: store data, right-aligned.
- `mem_wext`  in  EXT_WIDTH: extension bits written on every store beat.
- `mem_ready`  out  1: the controller accepts a request this cycle.
- `mem_done`  out  1: one-cycle completion pulse for both loads and stores.
- `mem_rdata`  out  32: load result, valid while `mem_done` is high.
- `mem_rext`  out  EXT_WIDTH: extension bits from the last read beat.
- `ram_addr`  out  ADDR_WIDTH: word address to the RAM.
- `ram_din`  out  EXT_WIDTH+32: write data to the RAM.
- `ram_write_en`  out  4: per-byte-lane write enables.
- `ram_dout`  in  EXT_WIDTH+32: RAM read data, valid one cycle after `ram_addr`.

## Operation
- Handshake
  - A request is accepted when `mem_req & mem_ready`.
  - `mem_ready` = (state == IDLE) & ~`sync_reset`.
  - Request inputs are sampled only in the accept cycle and held internally after that.
- Addressing
  - Word address W = `mem_addr[ADDR_WIDTH+1:2]`; byte offset o = `mem_addr[1:0]`; size s = 1, 2 or 4 bytes.
  - An access splits when o + s > 4: a half-word at o = 3, or a word at o ≠ 0. Byte accesses never split.
  - The second beat uses address W+1 mod 2^ADDR_WIDTH, so the last word wraps to word 0.
- Stores
  - The lane-shifted data is `{32'b0, mem_wdata} << 8*o`. Beat 1 carries bits [31:0] with lanes o..min(o+s,4)-1. Beat 2 carries bits [63:32] with lanes 0..o+s-5.
  - `ram_din` = {`mem_wext`, beat data} on every beat.
  - `ram_write_en` is 0 in every cycle that does not carry a store beat.
- Loads
  - Beat-1 data is captured into a buffer. The 64-bit word {beat2, beat1} is shifted right by 8*o and truncated to s bytes.
  - The result is sign-extended if `mem_sign_ext`, otherwise zero-extended, then registered into `mem_rdata`.
- State machine (states IDLE, RD_SPLIT, RD_LAST, WR_SPLIT):
  - IDLE, aligned load accepted → RD_LAST.
  - IDLE, split load accepted → RD_SPLIT.
  - IDLE, aligned store accepted → stays in IDLE; `mem_done` is pulsed on the next cycle.
  - IDLE, split store accepted → WR_SPLIT.
  - RD_SPLIT → RD_LAST, driving W+1.
  - RD_LAST → IDLE, with `mem_done` and the result registered.
  - WR_SPLIT → IDLE, issuing beat 2.
- Reset (all synchronous)
  - State returns to IDLE.
  - `mem_done`, `mem_rdata` and `mem_rext` are cleared to 0.
  - `ram_write_en` is 0 and `ram_addr` is 0 while IDLE with no request.
  - A reset during WR_SPLIT suppresses beat 2; beat 1 is already committed.
  - A reset during a load produces no `mem_done`.

## Timing
- T0 is the accept cycle; in T0 `ram_addr` = W, driven combinationally.
- Aligned store: RAM write at the T0 edge. `mem_done` at T1, and `mem_ready` is high again at T1.
- Split store: beat 1 at T0, beat 2 at T1. `mem_done` at T2.
- Aligned load: `ram_dout` valid at T1. `mem_done`/`mem_rdata` at T2, and `mem_ready` is high at T2.
- Split load: `ram_addr` = W+1 at T1; W data is captured at T1 and W+1 data arrives at T2. `mem_done` at T3.
- Maximum throughput is one aligned store per cycle and one aligned load every 2 cycles.

## Structure
- Package `sram_access_pkg` holds:
  - the state enum;
  - the width encodings (BYTE/HALF/WORD);
  - localparam NB = 4;
  - a split-detect function.
- Submodule `sram_lane_shifter` is purely combinational. It covers the store-side left shift with lane-enable generation, and the load-side right shift with sign/zero extension. It is instantiated once per direction.

## Test plan
- Aligned word store 0xDEADBEEF at byte address 0x10, then a load of the same address → `ram_write_en` = 4'hF at T0, `mem_done` at T1. The load returns 0xDEADBEEF at T2.
- Byte load at 0x13 from word 0x80FF0000 → `mem_sign_ext` = 1 returns 0xFFFFFF80; `mem_sign_ext` = 0 returns 0x00000080.
- Half store 0xABCD at offset 3 of word 5 → 4'h8 written at word 5 (byte 0xCD), then 4'h1 at word 6 (byte 0xAB). `mem_done` at T2; the load back returns 0x0000ABCD at T3.
- Word store at the last byte address 2^(ADDR_WIDTH+2)-1 → beat 2 goes to word 0 with lanes 4'h7.
- `sync_reset` asserted in WR_SPLIT → no beat-2 write, no `mem_done`, `mem_ready` = 1 the cycle after reset deasserts.
- `mem_req` held high through a split load → exactly one accept; `mem_ready` stays 0 from T1 to T2.
